// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID/EX pipeline boundary.
// The control bundle is the set of fields that a bubble clears.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination
// feeds a source of the instruction in ID. Register 0 is never a hazard.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             load_use
);

    always_comb begin
        load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                   ((ex_rt == id_rs) | (ex_rt == id_rt));
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble injection, branch flush,
// downstream hold and a saturating count of load-use bubble cycles.
module id_ex_pipe
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_W  = pipe_pkg::REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [1:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_pc_next,
    input  logic [DATA_W-1:0] id_branch_imm,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush,
    input  logic              hold_in,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic [1:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_pc_next,
    output logic [DATA_W-1:0] ex_branch_imm,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              stall_out,
    output logic [CNT_W-1:0]  stall_count
);

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d, ctrl_id;
    logic [DATA_W-1:0] pc_next_q, pc_next_d;
    logic [DATA_W-1:0] branch_imm_q, branch_imm_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [REG_W-1:0]  rt_q, rt_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              load_use;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .load_use    (load_use)
    );

    always_comb begin
        ctrl_id = '{reg_write:  id_reg_write,
                    mem_to_reg: id_mem_to_reg,
                    mem_read:   id_mem_read,
                    mem_write:  id_mem_write,
                    branch:     id_branch,
                    alu_src:    id_alu_src,
                    reg_dst:    id_reg_dst,
                    alu_op:     id_alu_op};

        valid_d       = valid_q;
        ctrl_d        = ctrl_q;
        pc_next_d     = pc_next_q;
        branch_imm_d  = branch_imm_q;
        rs_data_d     = rs_data_q;
        rt_data_d     = rt_data_q;
        rt_d          = rt_q;
        rd_d          = rd_q;
        stall_count_d = stall_count_q;

        // Bubbles still take the datapath fields; only valid and control matter.
        if (flush || (!hold_in && load_use)) begin
            valid_d      = 1'b0;
            ctrl_d       = BUBBLE;
            pc_next_d    = id_pc_next;
            branch_imm_d = id_branch_imm;
            rs_data_d    = id_rs_data;
            rt_data_d    = id_rt_data;
            rt_d         = id_rt;
            rd_d         = id_rd;
            if (!flush && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end else if (!hold_in) begin
            valid_d      = id_valid;
            ctrl_d       = ctrl_id;
            pc_next_d    = id_pc_next;
            branch_imm_d = id_branch_imm;
            rs_data_d    = id_rs_data;
            rt_data_d    = id_rt_data;
            rt_d         = id_rt;
            rd_d         = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            ctrl_q        <= BUBBLE;
            pc_next_q     <= '0;
            branch_imm_q  <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            ctrl_q        <= ctrl_d;
            pc_next_q     <= pc_next_d;
            branch_imm_q  <= branch_imm_d;
            rs_data_q     <= rs_data_d;
            rt_data_q     <= rt_data_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        ex_valid      = valid_q;
        ex_reg_write  = ctrl_q.reg_write;
        ex_mem_to_reg = ctrl_q.mem_to_reg;
        ex_mem_read   = ctrl_q.mem_read;
        ex_mem_write  = ctrl_q.mem_write;
        ex_branch     = ctrl_q.branch;
        ex_alu_src    = ctrl_q.alu_src;
        ex_reg_dst    = ctrl_q.reg_dst;
        ex_alu_op     = ctrl_q.alu_op;
        ex_pc_next    = pc_next_q;
        ex_branch_imm = branch_imm_q;
        ex_rs_data    = rs_data_q;
        ex_rt_data    = rt_data_q;
        ex_rt         = rt_q;
        ex_rd         = rd_q;
        stall_count   = stall_count_q;
        stall_out     = hold_in | load_use;
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe. The counter is narrowed to 4 bits so
// saturation is reachable in a few dozen cycles.
module tb_id_ex_pipe;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_reg_write, id_mem_to_reg, id_mem_read;
    logic          id_mem_write, id_branch, id_alu_src, id_reg_dst;
    logic [1:0]    id_alu_op;
    logic [DW-1:0] id_pc_next, id_branch_imm, id_rs_data, id_rt_data;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          flush, hold_in;
    logic          ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read;
    logic          ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst;
    logic [1:0]    ex_alu_op;
    logic [DW-1:0] ex_pc_next, ex_branch_imm, ex_rs_data, ex_rt_data;
    logic [RW-1:0] ex_rt, ex_rd;
    logic          stall_out;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt;

    id_ex_pipe #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .id_pc_next(id_pc_next),
        .id_branch_imm(id_branch_imm), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .hold_in(hold_in),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .ex_alu_op(ex_alu_op), .ex_pc_next(ex_pc_next),
        .ex_branch_imm(ex_branch_imm), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .stall_out(stall_out), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_valid = 0; id_reg_write = 0; id_mem_to_reg = 0; id_mem_read = 0;
        id_mem_write = 0; id_branch = 0; id_alu_src = 0; id_reg_dst = 0;
        id_alu_op = 2'b00; id_pc_next = '0; id_branch_imm = '0;
        id_rs_data = '0; id_rt_data = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    endtask

    task automatic id_lw(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
        id_clear();
        id_valid = 1; id_reg_write = 1; id_mem_to_reg = 1; id_mem_read = 1;
        id_alu_src = 1; id_rs = rs; id_rt = rt;
    endtask

    task automatic id_alu(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic [RW-1:0] rd);
        id_clear();
        id_valid = 1; id_reg_write = 1; id_reg_dst = 1; id_alu_op = 2'b10;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    initial begin
        id_clear();
        flush = 0; hold_in = 0; rst_n = 0;
        id_valid = 1; id_reg_write = 1; id_mem_to_reg = 1; id_mem_read = 1;
        id_mem_write = 1; id_branch = 1; id_alu_src = 1; id_reg_dst = 1;
        id_alu_op = 2'b11; id_pc_next = 32'hDEAD; id_rs_data = 32'h55;
        id_rs = 7; id_rt = 7; id_rd = 7;
        tick(); tick();
        chk("rst_valid",     32'(ex_valid), 0);
        chk("rst_reg_write", 32'(ex_reg_write), 0);
        chk("rst_mem_read",  32'(ex_mem_read), 0);
        chk("rst_mem_write", 32'(ex_mem_write), 0);
        chk("rst_alu_op",    32'(ex_alu_op), 0);
        chk("rst_pc_next",   ex_pc_next, 0);
        chk("rst_rs_data",   ex_rs_data, 0);
        chk("rst_rt",        32'(ex_rt), 0);
        chk("rst_count",     32'(stall_count), 0);
        chk("rst_stall_out", 32'(stall_out), 0);

        // pass-through
        rst_n = 1;
        id_alu(3, 4, 5);
        id_rs_data = 32'h11; id_pc_next = 32'h104; id_branch_imm = 32'h8;
        tick();
        chk("pt_valid",     32'(ex_valid), 1);
        chk("pt_reg_write", 32'(ex_reg_write), 1);
        chk("pt_alu_op",    32'(ex_alu_op), 2);
        chk("pt_rs_data",   ex_rs_data, 32'h11);
        chk("pt_pc_next",   ex_pc_next, 32'h104);
        chk("pt_imm",       ex_branch_imm, 32'h8);
        chk("pt_rt",        32'(ex_rt), 4);
        chk("pt_rd",        32'(ex_rd), 5);
        chk("pt_stall_out", 32'(stall_out), 0);

        // load-use: lw r2 then add using r2
        id_lw(1, 2);
        tick();
        chk("lu_ex_mem_read", 32'(ex_mem_read), 1);
        id_alu(2, 5, 6);
        #1;
        chk("lu_stall_out", 32'(stall_out), 1);
        tick();
        chk("lu_bub_valid", 32'(ex_valid), 0);
        chk("lu_bub_rw",    32'(ex_reg_write), 0);
        chk("lu_bub_mr",    32'(ex_mem_read), 0);
        chk("lu_count",     32'(stall_count), 1);
        chk("lu_stall_off", 32'(stall_out), 0);
        tick();
        chk("lu_adv_valid", 32'(ex_valid), 1);
        chk("lu_adv_rd",    32'(ex_rd), 6);
        chk("lu_adv_rdst",  32'(ex_reg_dst), 1);

        // back-to-back dependent loads stall once
        id_lw(1, 2);
        tick();
        id_lw(2, 3);
        #1;
        chk("b2b_stall", 32'(stall_out), 1);
        tick();
        chk("b2b_bub_valid", 32'(ex_valid), 0);
        tick();
        chk("b2b_mem_read", 32'(ex_mem_read), 1);
        chk("b2b_rt",       32'(ex_rt), 3);
        id_alu(7, 8, 9);
        #1;
        chk("b2b_no_stall", 32'(stall_out), 0);
        chk("b2b_count",    32'(stall_count), 2);

        // register 0 exemption
        id_lw(1, 0);
        tick();
        id_alu(0, 0, 4);
        #1;
        chk("r0_stall", 32'(stall_out), 0);
        tick();
        chk("r0_valid", 32'(ex_valid), 1);
        chk("r0_count", 32'(stall_count), 2);

        // flush beats hold and hazard
        id_lw(1, 2);
        tick();
        id_alu(2, 3, 4);
        id_mem_write = 1;
        flush = 1; hold_in = 1;
        #1;
        chk("fl_stall_out", 32'(stall_out), 1);
        tick();
        flush = 0; hold_in = 0;
        chk("fl_valid", 32'(ex_valid), 0);
        chk("fl_mw",    32'(ex_mem_write), 0);
        chk("fl_count", 32'(stall_count), 2);

        // hold for three cycles
        id_alu(1, 1, 9);
        id_pc_next = 32'h200;
        tick();
        id_alu(1, 1, 10);
        id_pc_next = 32'h300;
        hold_in = 1;
        #1;
        chk("hold_stall_out", 32'(stall_out), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_rd",    32'(ex_rd), 9);
            chk("hold_pc",    ex_pc_next, 32'h200);
            chk("hold_count", 32'(stall_count), 2);
        end
        hold_in = 0;
        tick();
        chk("unhold_rd", 32'(ex_rd), 10);
        chk("unhold_pc", ex_pc_next, 32'h300);

        // saturation of the 4-bit counter
        exp_cnt = 2;
        for (int i = 0; i < 15; i++) begin
            id_lw(1, 2);
            tick();
            id_alu(2, 2, 3);
            tick();
            if (exp_cnt < 15) exp_cnt++;
        end
        chk("sat_count", 32'(stall_count), 32'(exp_cnt));
        chk("sat_value", 32'(stall_count), 32'hF);

        // reset in the middle of a stall
        id_lw(1, 2);
        tick();
        id_alu(2, 2, 3);
        #1;
        chk("mid_stall", 32'(stall_out), 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mid_rst_valid", 32'(ex_valid), 0);
        chk("mid_rst_count", 32'(stall_count), 0);
        chk("mid_rst_stall", 32'(stall_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register with integrated load-use hazard detection. Sits between the decode stage and the execute stage.
- Latches decoded control, operands and register addresses every cycle.
- Detects a load in EX whose destination is needed by the instruction in ID. On detection it stalls the front end and injects a bubble into EX.
- Also handles branch flush from later stages, external hold from memory, and counts stall cycles.

Parameters:
- DATA_W, 32, width of pc_next, branch_imm, rs_data, rt_data.
- REG_W, 5, register-address width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst  in  1 each  decoded control.
- id_alu_op  in  2  decoded ALU op class.
- id_pc_next, id_branch_imm, id_rs_data, id_rt_data  in  DATA_W each  decoded datapath values.
- id_rs, id_rt, id_rd  in  REG_W each  register addresses.
- flush  in  1  branch resolved taken; kill the instruction entering EX.
- hold_in  in  1  downstream busy; freeze this register.
- ex_valid  out  1  EX holds a real instruction.
- ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst  out  1 each  registered control.
- ex_alu_op  out  2  registered ALU op class.
- ex_pc_next, ex_branch_imm, ex_rs_data, ex_rt_data  out  DATA_W each  registered datapath values.
- ex_rt, ex_rd  out  REG_W each  registered register addresses.
- stall_out  out  1  combinational; PC and IF/ID must hold.
- stall_count  out  CNT_W  registered; saturating count of load-use bubble cycles.

Behaviour:
- Reset (rst_n=0 at clk edge): every ex_* output = 0, ex_valid = 0, stall_count = 0. Reset overrides flush and hold. Reset mid-stall drops the stall; the cycle after reset, stall_out depends only on the current inputs.
- load_use (combinational) = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)). Register 0 never causes a hazard.
- stall_out = hold_in | load_use.
- Per-edge update priority, first match wins:
  1. Reset.
  2. flush=1: bubble. ex_valid=0, all control outputs 0; datapath fields may load from ID (don't-care). Applies even when hold_in=1.
  3. hold_in=1: all ex_* outputs keep their values.
  4. load_use=1: bubble (as for flush). stall_count increments unless it equals all-ones, in which case it saturates.
  5. Otherwise: load all ex_* outputs from the id_* inputs, and ex_valid = id_valid.
- A bubble forces reg_write, mem_read, mem_write and branch to 0. No architectural side effect may leak from a bubble.
- Latency: 1 cycle from ID to EX outputs.
- A load-use stall lasts exactly 1 cycle. After the bubble, ex_mem_read=0, so load_use deasserts and the held ID instruction advances on the next edge.
- Back-to-back dependent loads (lw r2; lw r3,0(r2)) stall exactly once.
- stall_count does not increment on flush or on hold_in cycles.
- stall_out is combinational from ex_* registers and id_* inputs only. No path from flush to stall_out.

Decomposition:
- Shared package `pipe_pkg`: REG_W and DATA_W constants; ALU_OP encodings (00 add, 01 sub, 10 funct); a control-bundle struct and its BUBBLE constant (all zeros).
- One natural sub-module: `hazard_detect` (purely combinational load_use computation).
- Register and counter stay in `id_ex_pipe`.

Test Plan:
- Reset → rst_n=0 for 2 cycles with id_valid=1 and all controls=1 → all ex_* = 0, ex_valid=0, stall_count=0.
- Pass-through → id_valid=1, id_rs=3, id_rt=4, id_rd=5, id_rs_data=0x11, id_alu_op=2'b10, reg_write=1 → the next cycle shows the same values on ex_*, ex_valid=1, stall_out=0.
- Load-use stall → EX holds a lw with ex_rt=2; ID presents add with id_rs=2 → stall_out=1 that cycle. Next cycle: ex_valid=0, controls 0, stall_count=1, stall_out=0. The following edge loads the add.
- $0 exemption → EX holds a lw with ex_rt=0; ID presents id_rs=0 → stall_out=0, no bubble, stall_count unchanged.
- Flush beats hold and hazard → flush=1, hold_in=1, load_use condition true → next cycle ex_valid=0, ex_mem_write=0, stall_count unchanged.
- Hold and saturation → hold_in=1 for 3 cycles: ex_* unchanged. Preload stall_count to 0xFFFF and trigger a load-use → stall_count stays 0xFFFF.
